instr_imm_decode: RTL and testbench
===================================

Name: instr_imm_decode

Overview:
- Decode-stage block that produces the operand-B controls the execute-stage ALU operand mux consumes: `imm_sel`, a sign-extended immediate, and the register addresses.
- Accepts fetched RV32I instructions over a valid/ready handshake.
- Extracts the I/S/B/U/J immediate and classifies the opcode.
- Presents the results through a registered 2-entry skid buffer, so backpressure from execute never loses or reorders instructions.

Parameters:
- XLEN, 32, datapath and immediate width
- TRACE_EN, 1, 1 = drive trace outputs, 0 = tie them to 0

Ports:
- clk_in  input  1  clock, all state updates on the rising edge
- rst_n_in  input  1  synchronous active-low reset
- flush_in  input  1  synchronous flush of all buffered entries (branch redirect)
- instr_valid_in  input  1  fetch offers an instruction
- instr_in  input  32  instruction word
- pc_in  input  XLEN  PC of the instruction
- instr_ready_out  output  1  decode can accept
- dec_valid_out  output  1  decoded entry valid
- dec_ready_in  input  1  execute accepts the entry
- imm_sel_out  output  1  1 = ALU operand B is the immediate
- imm_value_out  output  XLEN  fully extended immediate
- imm12_out  output  12  raw instr[31:20] for the legacy 12-bit operand path
- rs1_addr_out, rs2_addr_out, rd_addr_out  output  5 each  register addresses
- funct3_out  output  3  instr[14:12]
- opclass_out  output  4  opcode class code from the package
- pc_out  output  XLEN  PC of the entry
- illegal_out  output  1  unsupported encoding
- trace_instr_out  output  32  raw instruction of the output entry

Behaviour:
- Reset (rst_n_in=0 at an edge): skid buffer empty.
  - dec_valid_out=0, all data outputs 0.
  - instr_ready_out=1 from the first cycle after reset.
  - An in-flight transfer is discarded.
- Handshake:
  - Input transfer when instr_valid_in & instr_ready_out.
  - Output transfer when dec_valid_out & dec_ready_in.
  - dec_valid_out and all data outputs come straight from registers.
  - instr_ready_out = !skid_valid (registered state, no combinational path from dec_ready_in).
- Latency: 1 cycle from input transfer to dec_valid_out when the buffer is empty. Throughput is 1 per cycle while dec_ready_in=1.
- Buffer state machine:
  - EMPTY:
    - accept → ONE.
  - ONE (main valid):
    - accept & drain → ONE, main reloaded.
    - accept & !drain → TWO, new entry into skid.
    - drain & !accept → EMPTY.
  - TWO (main + skid, ready_out=0):
    - drain → ONE, skid moves to main.
    - otherwise hold.
- Flush:
  - Next state is EMPTY and dec_valid_out=0.
  - Flush takes priority over an accept in the same cycle; that instruction is dropped.
  - Flush has lower priority than reset.
- Immediates, decoded combinationally before the main/skid register:
  - I: sext(i[31:20])
  - S: sext({i[31:25],i[11:7]})
  - B: sext({i[31],i[7],i[30:25],i[11:8],0})
  - U: {i[31:12],12'b0}
  - J: sext({i[31],i[19:12],i[20],i[30:21],0})
- imm_sel_out=1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JAL, JALR.
- imm_sel_out=0 for OP, BRANCH, illegal.
- Shifts (SLLI/SRLI/SRAI) use the raw I-format value; the ALU uses bits[4:0].
- illegal_out=1 when i[1:0]!=2'b11 or the opcode is outside the list above. In that case imm_value_out=0, imm_sel_out=0, rd_addr_out=0.
- rs2_addr_out is always i[24:20], whatever the format.
- Trace outputs are 0 when TRACE_EN=0.

Decomposition:
- Package `rv_decode_pkg`: opcode localparams (7-bit) and the opclass enum (OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, ILLEGAL).
- Package also holds the decoded-entry struct (imm, imm_sel, addrs, funct3, opclass, pc, illegal, instr).
- Sub-module `imm_gen`: purely combinational instruction → {imm_value, imm_sel, opclass, illegal}.
- The top level holds the skid buffer and FSM.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), dec_ready_in=1 → next cycle: dec_valid_out=1, imm_value_out=0xFFFFFFFF, imm_sel_out=1, rd=1, rs1=0, imm12_out=0xFFF.
- sw x2,-4(x3) (0xFE21AE23) → imm=0xFFFFFFFC, imm_sel=1, rs1=3, rs2=2, opclass=STORE.
- beq x0,x0,-8 (0xFE000CE3) → imm=0xFFFFFFF8, imm_sel=0. Then lui x5,0x12345 (0x123452B7) → imm=0x12345000, rd=5.
- Stream 4 instrs with dec_ready_in=0 for 3 cycles → 2 accepted, instr_ready_out=0 from cycle 2. On release, all 4 emerge in order with no duplicates.
- State TWO with flush_in=1 and instr_valid_in=1 → next cycle dec_valid_out=0, instr_ready_out=1; the offered instr is never output.
- Instr 0x00000000 → illegal_out=1, imm=0, imm_sel=0. Reset asserted mid-stream for 1 cycle → dec_valid_out=0, all outputs 0, instr_ready_out=1 on the following cycle.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, opcode classes and the decoded-entry payload.
package rv_decode_pkg;

  localparam int unsigned XLEN_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    OC_OP      = 4'd0,
    OC_OPIMM   = 4'd1,
    OC_LOAD    = 4'd2,
    OC_STORE   = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LUI     = 4'd5,
    OC_AUIPC   = 4'd6,
    OC_JAL     = 4'd7,
    OC_JALR    = 4'd8,
    OC_ILLEGAL = 4'd9
  } opclass_e;

  typedef struct packed {
    logic [XLEN_W-1:0]  imm;
    logic               imm_sel;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [2:0]         funct3;
    opclass_e           opclass;
    logic [XLEN_W-1:0]  pc;
    logic               illegal;
    logic [INSTR_W-1:0] instr;
  } dec_entry_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction and opcode classification.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_value_c,
  output logic            imm_sel_c,
  output opclass_e        opclass_c,
  output logic            illegal_c
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Anything not matched below stays illegal with a zero immediate.
  always_comb begin
    imm_value_c = '0;
    imm_sel_c   = 1'b0;
    opclass_c   = OC_ILLEGAL;
    illegal_c   = 1'b1;
    if (instr[1:0] == 2'b11) begin
      unique case (instr[6:0])
        OPC_OP: begin
          opclass_c = OC_OP;
          illegal_c = 1'b0;
        end
        OPC_OPIMM: begin
          imm_value_c = XLEN'($signed(imm_i));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_OPIMM;
          illegal_c   = 1'b0;
        end
        OPC_LOAD: begin
          imm_value_c = XLEN'($signed(imm_i));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_LOAD;
          illegal_c   = 1'b0;
        end
        OPC_STORE: begin
          imm_value_c = XLEN'($signed(imm_s));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_STORE;
          illegal_c   = 1'b0;
        end
        OPC_BRANCH: begin
          imm_value_c = XLEN'($signed(imm_b));
          opclass_c   = OC_BRANCH;
          illegal_c   = 1'b0;
        end
        OPC_LUI: begin
          imm_value_c = XLEN'($signed(imm_u));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_LUI;
          illegal_c   = 1'b0;
        end
        OPC_AUIPC: begin
          imm_value_c = XLEN'($signed(imm_u));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_AUIPC;
          illegal_c   = 1'b0;
        end
        OPC_JAL: begin
          imm_value_c = XLEN'($signed(imm_j));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_JAL;
          illegal_c   = 1'b0;
        end
        OPC_JALR: begin
          imm_value_c = XLEN'($signed(imm_i));
          imm_sel_c   = 1'b1;
          opclass_c   = OC_JALR;
          illegal_c   = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_imm_decode.sv
// Decode stage: immediate/operand-B control extraction behind a registered 2-entry skid buffer.
module instr_imm_decode
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          TRACE_EN = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            instr_valid_in,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            instr_ready_out,
  output logic            dec_valid_out,
  input  logic            dec_ready_in,
  output logic            imm_sel_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [11:0]     imm12_out,
  output logic [4:0]      rs1_addr_out,
  output logic [4:0]      rs2_addr_out,
  output logic [4:0]      rd_addr_out,
  output logic [2:0]      funct3_out,
  output logic [3:0]      opclass_out,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal_out,
  output logic [31:0]     trace_instr_out
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e state_q;
  dec_entry_t main_q, skid_q, dec_c;
  logic       dec_valid_q, ready_q;
  logic       accept_c, drain_c;

  logic [XLEN-1:0] gen_imm_c;
  logic            gen_sel_c, gen_ill_c;
  opclass_e        gen_oc_c;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr       (instr_in),
    .imm_value_c (gen_imm_c),
    .imm_sel_c   (gen_sel_c),
    .opclass_c   (gen_oc_c),
    .illegal_c   (gen_ill_c)
  );

  // Assemble the entry that an accepted instruction writes into the buffer.
  always_comb begin
    dec_c         = '0;
    dec_c.imm     = XLEN_W'(gen_imm_c);
    dec_c.imm_sel = gen_sel_c;
    dec_c.rs1     = instr_in[19:15];
    dec_c.rs2     = instr_in[24:20];
    dec_c.rd      = gen_ill_c ? 5'd0 : instr_in[11:7];
    dec_c.funct3  = instr_in[14:12];
    dec_c.opclass = gen_oc_c;
    dec_c.pc      = XLEN_W'(pc_in);
    dec_c.illegal = gen_ill_c;
    dec_c.instr   = instr_in;
  end

  assign accept_c = instr_valid_in & ready_q;
  assign drain_c  = dec_valid_q & dec_ready_in;

  // Skid buffer: main feeds the outputs, skid catches one beat while execute stalls.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      dec_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else if (flush_in) begin
      state_q     <= ST_EMPTY;
      dec_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_q      <= dec_c;
            dec_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            main_q <= dec_c;
          end else if (accept_c) begin
            skid_q  <= dec_c;
            ready_q <= 1'b0;
            state_q <= ST_TWO;
          end else if (drain_c) begin
            dec_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain_c) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          dec_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready_out = ready_q;
  assign dec_valid_out   = dec_valid_q;
  assign imm_sel_out     = main_q.imm_sel;
  assign imm_value_out   = XLEN'(main_q.imm);
  assign imm12_out       = main_q.instr[31:20];
  assign rs1_addr_out    = main_q.rs1;
  assign rs2_addr_out    = main_q.rs2;
  assign rd_addr_out     = main_q.rd;
  assign funct3_out      = main_q.funct3;
  assign opclass_out     = main_q.opclass;
  assign pc_out          = XLEN'(main_q.pc);
  assign illegal_out     = main_q.illegal;

  generate
    if (TRACE_EN) begin : g_trace
      assign trace_instr_out = main_q.instr;
    end else begin : g_no_trace
      assign trace_instr_out = '0;
    end
  endgenerate

endmodule

// File: tb/tb_instr_imm_decode.sv
// Directed bench for instr_imm_decode: decode table plus backpressure, flush and reset sequences.
module tb_instr_imm_decode;
  import rv_decode_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, flush_in, instr_valid_in, dec_ready_in;
  logic [31:0] instr_in, pc_in;
  logic        instr_ready_out, dec_valid_out, imm_sel_out, illegal_out;
  logic [31:0] imm_value_out, pc_out, trace_instr_out;
  logic [11:0] imm12_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [2:0]  funct3_out;
  logic [3:0]  opclass_out;

  int n_checks = 0;
  int n_fail   = 0;

  instr_imm_decode #(.XLEN(32), .TRACE_EN(1'b1)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .flush_in        (flush_in),
    .instr_valid_in  (instr_valid_in),
    .instr_in        (instr_in),
    .pc_in           (pc_in),
    .instr_ready_out (instr_ready_out),
    .dec_valid_out   (dec_valid_out),
    .dec_ready_in    (dec_ready_in),
    .imm_sel_out     (imm_sel_out),
    .imm_value_out   (imm_value_out),
    .imm12_out       (imm12_out),
    .rs1_addr_out    (rs1_addr_out),
    .rs2_addr_out    (rs2_addr_out),
    .rd_addr_out     (rd_addr_out),
    .funct3_out      (funct3_out),
    .opclass_out     (opclass_out),
    .pc_out          (pc_out),
    .illegal_out     (illegal_out),
    .trace_instr_out (trace_instr_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        sel;
    logic [11:0] imm12;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    opclass_e    oc;
    logic        ill;
    logic        chk_imm;
  } vec_t;

  localparam int NV = 12;
  vec_t        vecs[NV];
  logic [31:0] seq[4];
  int          sent, recv;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1'b1, 12'hFFF, 5'd0,  5'd31, 5'd1,  3'd0, OC_OPIMM,   1'b0, 1'b1};
    vecs[1]  = '{32'hFE21AE23, 32'hFFFFFFFC, 1'b1, 12'hFE2, 5'd3,  5'd2,  5'd28, 3'd2, OC_STORE,   1'b0, 1'b1};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 1'b0, 12'hFE0, 5'd0,  5'd0,  5'd25, 3'd0, OC_BRANCH,  1'b0, 1'b1};
    vecs[3]  = '{32'h123452B7, 32'h12345000, 1'b1, 12'h123, 5'd8,  5'd3,  5'd5,  3'd5, OC_LUI,     1'b0, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 1'b0, 12'h000, 5'd0,  5'd0,  5'd0,  3'd0, OC_ILLEGAL, 1'b1, 1'b1};
    vecs[5]  = '{32'h008000EF, 32'h00000008, 1'b1, 12'h008, 5'd0,  5'd8,  5'd1,  3'd0, OC_JAL,     1'b0, 1'b1};
    vecs[6]  = '{32'h000080E7, 32'h00000000, 1'b1, 12'h000, 5'd1,  5'd0,  5'd1,  3'd0, OC_JALR,    1'b0, 1'b1};
    vecs[7]  = '{32'hFFFFF117, 32'hFFFFF000, 1'b1, 12'hFFF, 5'd31, 5'd31, 5'd2,  3'd7, OC_AUIPC,   1'b0, 1'b1};
    vecs[8]  = '{32'h01012283, 32'h00000010, 1'b1, 12'h010, 5'd2,  5'd16, 5'd5,  3'd2, OC_LOAD,    1'b0, 1'b1};
    vecs[9]  = '{32'h002081B3, 32'h00000000, 1'b0, 12'h002, 5'd1,  5'd2,  5'd3,  3'd0, OC_OP,      1'b0, 1'b0};
    vecs[10] = '{32'h40325213, 32'h00000403, 1'b1, 12'h403, 5'd4,  5'd3,  5'd4,  3'd5, OC_OPIMM,   1'b0, 1'b1};
    vecs[11] = '{32'hFFF00091, 32'h00000000, 1'b0, 12'hFFF, 5'd0,  5'd31, 5'd0,  3'd0, OC_ILLEGAL, 1'b1, 1'b1};
    seq[0] = 32'h00100093;
    seq[1] = 32'h00200113;
    seq[2] = 32'h00300193;
    seq[3] = 32'h00400213;

    rst_n_in = 1'b0; flush_in = 1'b0; instr_valid_in = 1'b0;
    instr_in = '0; pc_in = '0; dec_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_valid", 32'(dec_valid_out), 32'd0);
    check("reset_ready", 32'(instr_ready_out), 32'd1);
    check("reset_imm", imm_value_out, 32'd0);
    check("reset_trace", trace_instr_out, 32'd0);
    rst_n_in = 1'b1;

    // Decode table, streamed back to back with execute always ready.
    for (int i = 0; i < NV; i++) begin
      instr_valid_in = 1'b1;
      instr_in       = vecs[i].instr;
      pc_in          = 32'h1000 + 32'(i) * 4;
      dec_ready_in   = 1'b1;
      @(posedge clk_in);
      #1;
      check($sformatf("v%0d_valid", i), 32'(dec_valid_out), 32'd1);
      if (vecs[i].chk_imm) check($sformatf("v%0d_imm", i), imm_value_out, vecs[i].imm);
      check($sformatf("v%0d_sel", i), 32'(imm_sel_out), 32'(vecs[i].sel));
      check($sformatf("v%0d_imm12", i), 32'(imm12_out), 32'(vecs[i].imm12));
      check($sformatf("v%0d_rs1", i), 32'(rs1_addr_out), 32'(vecs[i].rs1));
      check($sformatf("v%0d_rs2", i), 32'(rs2_addr_out), 32'(vecs[i].rs2));
      check($sformatf("v%0d_rd", i), 32'(rd_addr_out), 32'(vecs[i].rd));
      check($sformatf("v%0d_f3", i), 32'(funct3_out), 32'(vecs[i].f3));
      check($sformatf("v%0d_oc", i), 32'(opclass_out), 32'(vecs[i].oc));
      check($sformatf("v%0d_ill", i), 32'(illegal_out), 32'(vecs[i].ill));
      check($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_trace", i), trace_instr_out, vecs[i].instr);
    end
    instr_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("table_drained", 32'(dec_valid_out), 32'd0);

    // Backpressure: execute stalls three cycles while four instructions are offered.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 30 && recv < 4; c++) begin
      dec_ready_in   = (c >= 3);
      instr_valid_in = (sent < 4);
      instr_in       = (sent < 4) ? seq[sent] : 32'h0;
      pc_in          = 32'h3000 + 32'(sent) * 4;
      @(negedge clk_in);
      if (c == 2) begin
        check("bp_ready_low", 32'(instr_ready_out), 32'd0);
        check("bp_accepted", 32'(sent), 32'd2);
        check("bp_head_trace", trace_instr_out, seq[0]);
      end
      if (dec_valid_out && dec_ready_in) begin
        check($sformatf("bp_out%0d_trace", recv), trace_instr_out, seq[recv]);
        check($sformatf("bp_out%0d_pc", recv), pc_out, 32'h3000 + 32'(recv) * 4);
        recv++;
      end
      if (instr_valid_in && instr_ready_out) sent++;
      @(posedge clk_in);
      #1;
    end
    check("bp_all_received", 32'(recv), 32'd4);
    instr_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("bp_no_dup", 32'(dec_valid_out), 32'd0);

    // Flush while full, with a new instruction offered in the same cycle.
    dec_ready_in   = 1'b0;
    instr_valid_in = 1'b1;
    instr_in       = seq[1];
    @(posedge clk_in);
    #1;
    instr_in = seq[2];
    @(posedge clk_in);
    #1;
    check("fl_full_ready", 32'(instr_ready_out), 32'd0);
    check("fl_full_valid", 32'(dec_valid_out), 32'd1);
    flush_in = 1'b1;
    instr_in = seq[3];
    @(posedge clk_in);
    #1;
    check("fl_valid", 32'(dec_valid_out), 32'd0);
    check("fl_ready", 32'(instr_ready_out), 32'd1);
    flush_in       = 1'b0;
    instr_valid_in = 1'b0;
    dec_ready_in   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in);
      #1;
      check($sformatf("fl_quiet%0d", k), 32'(dec_valid_out), 32'd0);
    end

    // Reset for one cycle mid-stream with a transfer in flight.
    dec_ready_in   = 1'b0;
    instr_valid_in = 1'b1;
    instr_in       = 32'hFFF00093;
    pc_in          = 32'h2000;
    @(posedge clk_in);
    #1;
    instr_in = 32'hFE21AE23;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    instr_in = 32'h123452B7;
    @(posedge clk_in);
    #1;
    check("rst_valid", 32'(dec_valid_out), 32'd0);
    check("rst_ready", 32'(instr_ready_out), 32'd1);
    check("rst_imm", imm_value_out, 32'd0);
    check("rst_sel", 32'(imm_sel_out), 32'd0);
    check("rst_imm12", 32'(imm12_out), 32'd0);
    check("rst_rs1", 32'(rs1_addr_out), 32'd0);
    check("rst_rs2", 32'(rs2_addr_out), 32'd0);
    check("rst_rd", 32'(rd_addr_out), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_trace", trace_instr_out, 32'd0);
    rst_n_in       = 1'b1;
    instr_valid_in = 1'b0;
    dec_ready_in   = 1'b1;
    @(posedge clk_in);
    #1;
    check("rst_after_valid", 32'(dec_valid_out), 32'd0);
    check("rst_after_ready", 32'(instr_ready_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
